// File: rtl/cpu_seq_fsm_if.sv
// rtl/cpu_seq_fsm_if.sv - instruction/data memory request/ready handshake bundle
interface cpu_seq_fsm_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic dmem_we;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/cpu_seq_fsm.sv
// rtl/cpu_seq_fsm.sv - multi-cycle RV32I sequencer (fetch/decode/exec/mem/wb)
// Optional memory wait timeout built when SEQ_TIMEOUT_EN is defined.
module cpu_seq_fsm #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    input  logic [31:0]   inst_i,
    cpu_seq_fsm_if.master mem,
    output logic          irw_en_o,
    output logic          regw_en_o,
    output logic          pcw_en_o,
    output logic          retire_o,
    output logic          halted_o,
    output logic [1:0]    fault_o,
    output logic [2:0]    state_o,
    output logic [31:0]   instret_o
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD, C_STORE, C_BRANCH, C_ALU, C_SYSTEM, C_ILLEGAL
    } opc_t;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_SYSTEM  = 2'b01;
    localparam logic [1:0] F_ILLEGAL = 2'b10;
    localparam logic [1:0] F_TIMEOUT = 2'b11;

    state_t      state_q, state_d;
    opc_t        opc_q, opc_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] instret_q;
    logic        waiting;
    logic        timeout_hit;

    always_comb begin
        case (inst_i[6:0])
            7'b0000011: opc_d = C_LOAD;
            7'b0100011: opc_d = C_STORE;
            7'b1100011: opc_d = C_BRANCH;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: opc_d = C_ALU;
            7'b1110011: opc_d = C_SYSTEM;
            default:    opc_d = C_ILLEGAL;
        endcase
    end

    assign waiting = ((state_q == S_FETCH) && run_i && !mem.imem_ready)
                   || ((state_q == S_MEM) && !mem.dmem_ready);

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        irw_en_o     = 1'b0;
        regw_en_o    = 1'b0;
        pcw_en_o     = 1'b0;
        retire_o     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem.imem_req = run_i;
                if (run_i && mem.imem_ready) begin
                    irw_en_o = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opc_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH: begin
                        pcw_en_o = 1'b1;
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_ALU:    state_d = S_WB;
                    C_SYSTEM: begin
                        state_d = S_HALT;
                        fault_d = F_SYSTEM;
                    end
                    default: begin
                        state_d = S_HALT;
                        fault_d = F_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (opc_q == C_STORE);
                if (mem.dmem_ready) begin
                    if (opc_q == C_STORE) begin
                        pcw_en_o = 1'b1;
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regw_en_o = 1'b1;
                pcw_en_o  = 1'b1;
                retire_o  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                state_d = S_HALT;
                fault_d = F_ILLEGAL;
            end
        endcase
        // Timeout overrides the handshake outcome of the same cycle.
        if (timeout_hit) begin
            state_d = S_HALT;
            fault_d = F_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opc_q     <= C_ILLEGAL;
            fault_q   <= F_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_q == S_DECODE) opc_q <= opc_d;
            if (retire_o) instret_q <= instret_q + 32'd1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_q, wait_d;

    // Any state change clears the count; counting only happens in FETCH and MEM.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) wait_d = '0;
        else if (waiting)       wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end

    assign timeout_hit = waiting && (wait_q == WAIT_LAST);
    wire unused_inst = ^inst_i[31:7];
`else
    assign timeout_hit = 1'b0;
    wire unused_cfg = ^{inst_i[31:7], waiting, 32'(TIMEOUT_CYC)};
`endif

    assign halted_o  = (state_q == S_HALT);
    assign fault_o   = fault_q;
    assign state_o   = state_q;
    assign instret_o = instret_q;
endmodule

// File: tb/tb_cpu_seq_fsm.sv
// tb/tb_cpu_seq_fsm.sv - directed self-checking bench for cpu_seq_fsm
module tb_cpu_seq_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] inst;
    logic        irw_en, regw_en, pcw_en, retire, halted;
    logic [1:0]  fault;
    logic [2:0]  state;
    logic [31:0] instret;
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_LW   = 32'h0000A083;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_ECAL = 32'h00000073;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    cpu_seq_fsm_if mem_if ();

    cpu_seq_fsm #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_i     (run),
        .inst_i    (inst),
        .mem       (mem_if),
        .irw_en_o  (irw_en),
        .regw_en_o (regw_en),
        .pcw_en_o  (pcw_en),
        .retire_o  (retire),
        .halted_o  (halted),
        .fault_o   (fault),
        .state_o   (state),
        .instret_o (instret)
    );

    always #5 clk = ~clk;

    // {state, irwEn, imem_req, dmem_req, dmem_we, regwEn, pcwEn, retire}
    function automatic logic [31:0] outs();
        return {22'd0, state, irw_en, mem_if.imem_req, mem_if.dmem_req,
                mem_if.dmem_we, regw_en, pcw_en, retire};
    endfunction

    function automatic logic [31:0] ev(input logic [2:0] st, input logic [6:0] b);
        return {22'd0, st, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; run = 1'b1; inst = 32'h0;
        mem_if.imem_ready = 1'b0; mem_if.dmem_ready = 1'b0;
        #2;
        chk("reset_outs", outs(), ev(3'd0, 7'b0100000));
        chk("reset_instret", instret, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        run = 1'b0; #1;
        chk("reset_run0", outs(), ev(3'd0, 7'b0000000));
        run = 1'b1;

        // add: F D E W
        @(negedge clk); rst = 1'b0; inst = I_ADD; mem_if.imem_ready = 1'b1; #1;
        chk("add_fetch", outs(), ev(3'd0, 7'b1100000));
        @(negedge clk); #1; chk("add_decode", outs(), ev(3'd1, 7'b0000000));
        @(negedge clk); #1; chk("add_exec", outs(), ev(3'd2, 7'b0000000));
        @(negedge clk); #1; chk("add_wb", outs(), ev(3'd4, 7'b0000111));

        // lw with three data wait cycles: F D E M M M M W
        @(negedge clk); inst = I_LW; #1;
        chk("add_instret", instret, 32'd1);
        chk("lw_fetch", outs(), ev(3'd0, 7'b1100000));
        @(negedge clk); #1; chk("lw_decode", outs(), ev(3'd1, 7'b0000000));
        @(negedge clk); #1; chk("lw_exec", outs(), ev(3'd2, 7'b0000000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1; chk("lw_mem_wait", outs(), ev(3'd3, 7'b0010000));
        end
        @(negedge clk); mem_if.dmem_ready = 1'b1; #1;
        chk("lw_mem_ready", outs(), ev(3'd3, 7'b0010000));
        @(negedge clk); #1; chk("lw_wb", outs(), ev(3'd4, 7'b0000111));

        // sw with zero-wait data memory: F D E M
        @(negedge clk); inst = I_SW; #1;
        chk("lw_instret", instret, 32'd2);
        chk("sw_fetch", outs(), ev(3'd0, 7'b1100000));
        @(negedge clk); #1; chk("sw_decode", outs(), ev(3'd1, 7'b0000000));
        @(negedge clk); #1; chk("sw_exec", outs(), ev(3'd2, 7'b0000000));
        @(negedge clk); #1; chk("sw_mem", outs(), ev(3'd3, 7'b0011011));

        // beq: F D E
        @(negedge clk); inst = I_BEQ; #1;
        chk("sw_instret", instret, 32'd3);
        chk("beq_fetch", outs(), ev(3'd0, 7'b1100000));
        @(negedge clk); #1; chk("beq_decode", outs(), ev(3'd1, 7'b0000000));
        @(negedge clk); #1; chk("beq_exec", outs(), ev(3'd2, 7'b0000011));

        // ecall: F D E HALT
        @(negedge clk); inst = I_ECAL; #1;
        chk("beq_instret", instret, 32'd4);
        chk("ecall_fetch", outs(), ev(3'd0, 7'b1100000));
        @(negedge clk); #1; chk("ecall_decode", outs(), ev(3'd1, 7'b0000000));
        @(negedge clk); #1; chk("ecall_exec", outs(), ev(3'd2, 7'b0000000));
        @(negedge clk); inst = I_ADD; #1;
        chk("ecall_halt", outs(), ev(3'd5, 7'b0000000));
        chk("ecall_halted", 32'(halted), 32'd1);
        chk("ecall_fault", 32'(fault), 32'd1);
        @(negedge clk); @(negedge clk); #1;
        chk("halt_stays", outs(), ev(3'd5, 7'b0000000));
        chk("halt_instret", instret, 32'd4);

        // reset leaves HALT; then illegal opcode
        rst = 1'b1; mem_if.imem_ready = 1'b0; #1;
        chk("rst2_outs", outs(), ev(3'd0, 7'b0100000));
        chk("rst2_fault", 32'(fault), 32'd0);
        @(negedge clk); rst = 1'b0; inst = I_ILL;
        mem_if.imem_ready = 1'b1; mem_if.dmem_ready = 1'b0; #1;
        chk("ill_fetch", outs(), ev(3'd0, 7'b1100000));
        @(negedge clk); @(negedge clk); #1;
        chk("ill_exec", outs(), ev(3'd2, 7'b0000000));
        @(negedge clk); #1;
        chk("ill_halt", outs(), ev(3'd5, 7'b0000000));
        chk("ill_fault", 32'(fault), 32'd2);

        // reset asserted mid-MEM aborts the load
        rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; inst = I_LW; #1;
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        chk("abort_mem", outs(), ev(3'd3, 7'b0010000));
        #1; rst = 1'b1; mem_if.imem_ready = 1'b0; #1;
        chk("abort_outs", outs(), ev(3'd0, 7'b0100000));
        chk("abort_instret", instret, 32'd0);

        // instruction memory never ready
        @(negedge clk); rst = 1'b0; #1;
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1; chk("tmo_wait", outs(), ev(3'd0, 7'b0100000));
        end
        @(negedge clk); #1;
        chk("tmo_halt", outs(), ev(3'd5, 7'b0000000));
        chk("tmo_fault", 32'(fault), 32'd3);
`else
        for (int i = 0; i < 300; i++) @(negedge clk);
        #1;
        chk("nowait_fetch", outs(), ev(3'd0, 7'b0100000));
        chk("nowait_fault", 32'(fault), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
